// File: rtl/audio_frame_arbiter.sv
`default_nettype none
// ============================================================================
// audio_frame_arbiter : round-robin, frame-locked merge of N_CH sample streams
// Revision : 1.0
// ============================================================================
module audio_frame_arbiter #(
   parameter int DATA_W = 16,
   parameter int N_CH   = 4,
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [15:0]            max_len,
   input  logic [N_CH-1:0]        s_valid,
   output logic [N_CH-1:0]        s_ready,
   input  logic [N_CH*DATA_W-1:0] s_data,
   input  logic [N_CH-1:0]        s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_W-1:0]      m_data,
   output logic                   m_last,
   output logic [CH_W-1:0]        m_chan,
   output logic                   frame_done,
   output logic [CH_W-1:0]        done_chan,
   output logic                   trunc
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t          r_state;
   logic [CH_W-1:0] r_gnt;
   logic [CH_W-1:0] r_rr_ptr;
   logic [15:0]     r_beat_cnt;

   logic            w_any;
   logic [CH_W-1:0] w_pick;
   logic [CH_W-1:0] w_idx;
   logic [CH_W-1:0] w_next;
   int              w_sum;
   logic            w_locked;
   logic            w_hs;
   logic            w_limit;
   logic            w_final;

   // First requester at or above the round-robin pointer, wrapping once.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_idx  = '0;
      w_sum  = 0;
      for (int k = 0; k < N_CH; k++) begin
         w_sum = int'(r_rr_ptr) + k;
         if (w_sum >= N_CH) w_sum = w_sum - N_CH;
         w_idx = CH_W'(w_sum);
         if (!w_any && s_valid[w_idx]) begin
            w_any  = 1'b1;
            w_pick = w_idx;
         end
      end
   end

   assign w_locked = (r_state == ST_LOCKED);
   assign m_valid  = w_locked & s_valid[r_gnt];
   assign m_data   = w_locked ? s_data[r_gnt*DATA_W +: DATA_W] : '0;
   assign m_chan   = r_gnt;
   assign w_hs     = m_valid & m_ready;
   assign w_limit  = (max_len != 16'd0) && ((r_beat_cnt + 16'd1) == max_len);
   assign w_final  = s_last[r_gnt] | w_limit;
   assign m_last   = w_locked & w_final;
   assign w_next   = (r_gnt == CH_W'(N_CH - 1)) ? '0 : r_gnt + CH_W'(1);

   always_comb begin
      s_ready = '0;
      if (w_locked) s_ready[r_gnt] = m_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_gnt      <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
         frame_done <= 1'b0;
         done_chan  <= '0;
         trunc      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         trunc      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (en && w_any) begin
                  r_gnt      <= w_pick;
                  r_beat_cnt <= '0;
                  r_state    <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (w_hs) begin
                  r_beat_cnt <= r_beat_cnt + 16'd1;
                  if (w_final) begin
                     // A frame cut by max_len is flagged so the RMS path can discard it.
                     r_state    <= ST_IDLE;
                     r_rr_ptr   <= w_next;
                     frame_done <= 1'b1;
                     done_chan  <= r_gnt;
                     trunc      <= ~s_last[r_gnt];
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/audio_frame_arbiter.md
AUDIO_FRAME_ARBITER -- requirements
Module: audio_frame_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter N_CH, default 4, number of input streams (2..8); CH_W = max(1, clog2(N_CH)).
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  1 = new grants allowed; 0 = finish current frame, then stop granting.
REQ-006 max_len  input  16  frame beat limit; 0 = unlimited.
REQ-007 s_valid  input  N_CH  per-channel AXI-Stream valid.
REQ-008 s_ready  output  N_CH  per-channel ready.
REQ-009 s_data  input  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 s_last  input  N_CH  per-channel end-of-frame.
REQ-011 m_valid  output  1  merged stream valid to the peak/RMS path.
REQ-012 m_ready  input  1  downstream ready.
REQ-013 m_data  output  DATA_W  merged sample.
REQ-014 m_last  output  1  merged end-of-frame.
REQ-015 m_chan  output  CH_W  channel ID of the current beat.
REQ-016 frame_done  output  1  one-cycle pulse, registered, after final beat of a frame transfers.
REQ-017 done_chan  output  CH_W  channel of the completed frame; valid while frame_done=1.
REQ-018 trunc  output  1  one-cycle pulse, coincident with frame_done, when the frame ended by max_len rather than s_last.

Function
REQ-019 FSM has two states: IDLE and LOCKED.
REQ-020 IDLE: m_valid=0, all s_ready=0; if en=1 and any s_valid=1, grant the first requesting channel searching upward from rr_ptr with wrap, register gnt, go to LOCKED next cycle (one-cycle arbitration latency).
REQ-021 IDLE with en=0 or no s_valid: remain in IDLE, no state change.
REQ-022 LOCKED: m_valid=s_valid[gnt], m_data=s_data[gnt], m_chan=gnt, s_ready[gnt]=m_ready, all other s_ready=0; purely combinational pass-through, zero added latency.
REQ-023 Handshake = m_valid & m_ready; beat_cnt (16 bits) increments per handshake and is cleared on entering LOCKED.
REQ-024 Final beat: s_last[gnt]=1, or max_len!=0 and beat_cnt+1 == max_len.
REQ-025 m_last = 1 on the final beat, including forced-last when max_len is hit with s_last[gnt]=0.
REQ-026 On final-beat handshake: go to IDLE, rr_ptr <= gnt+1 modulo N_CH, frame_done=1 and done_chan=gnt the next cycle, trunc=1 the same cycle only if s_last[gnt] was 0.
REQ-027 After truncation, further beats of that channel form a new frame subject to fresh arbitration.
REQ-028 en deasserted in LOCKED: current frame completes normally; no new grant until en=1.
REQ-029 Changes to max_len mid-frame take effect on the next beat compared.
REQ-030 A channel with s_valid=0 mid-frame stalls the merged stream; grant is held, no timeout.
REQ-031 Back-to-back frames: minimum one IDLE cycle between the final beat of one frame and the first beat of the next.
REQ-032 Round-robin fairness: with all N_CH channels continuously requesting, grants cycle 0,1,..,N_CH-1,0.

Reset
REQ-033 rst_n low, asynchronously: state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0, frame_done=0, done_chan=0, trunc=0; hence m_valid=0, s_ready=0.
REQ-034 Reset mid-frame abandons the frame with no frame_done pulse; first grant after release searches from channel 0.

Verification
REQ-035 Single channel: ch2 sends 4 beats, last on beat 4, m_ready=1 -> m_chan=2 for 4 beats, m_last on beat 4, frame_done=1 with done_chan=2, trunc=0.
REQ-036 All 4 channels requesting continuously, 2-beat frames -> grant order 0,1,2,3,0 with one IDLE cycle between frames.
REQ-037 max_len=3, ch1 sends 5 beats, last on beat 5 -> m_last forced on beat 3, trunc=1; beats 4-5 delivered as a new 2-beat frame later, trunc=0.
REQ-038 Backpressure: m_ready toggled 1,0,0,1 mid-frame -> s_ready[gnt] tracks m_ready, no beat lost or duplicated, data order preserved.
REQ-039 en dropped on beat 2 of a 4-beat frame -> frame completes with frame_done, then m_valid stays 0 despite pending s_valid until en=1.
REQ-040 rst_n asserted on beat 2 of ch3 frame -> outputs at reset values immediately, no frame_done; after release with ch3 and ch0 requesting, ch0 granted first.
